// File: rtl/tdc_fifo_regslave_if.sv
`default_nettype none
// tdc_fifo_regslave_if: strobe/address group from the AXI4-Lite bridge to the register slave.
// Revision 1.0
interface tdc_fifo_regslave_if;
   logic        writesignal;
   logic        readsignal;
   logic [15:0] addressbus;

   modport master (output writesignal, readsignal, addressbus);
   modport slave  (input  writesignal, readsignal, addressbus);
endinterface
`default_nettype wire

// File: rtl/tdc_fifo_regslave.sv
`default_nettype none
// tdc_fifo_regslave: TDC hit FIFO behind a CTRL/STATUS/DATA/DROP local-bus register window.
// Revision 1.0
module tdc_fifo_regslave #(
   parameter logic [15:0] base_offset = 16'h0100,
   parameter int          DEPTH       = 512,
   parameter int          AW          = 9
) (
   input  wire logic           axi_aclk,
   input  wire logic           axi_aresetn,
   tdc_fifo_regslave_if.slave  bus,
   inout  wire  [31:0]         databus,
   input  wire logic [31:0]    in_data,
   input  wire logic           in_valid,
   output logic                run_enable,
   output logic                fifo_empty,
   output logic [AW:0]         fifo_count
);

   localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   drop;
   logic [31:0]   rd_hold;
   logic          rd_active;

   logic          in_window;
   logic          reg_ok;
   logic          ctrl_hit;
   logic          data_hit;
   logic          full;
   logic          clear;
   logic          pop;
   logic          push;
   logic          drop_inc;
   logic [31:0]   status;
   logic [31:0]   rd_sel;
   logic          unused_bus;

   assign in_window = (bus.addressbus[15:4] == base_offset[15:4]);
   assign reg_ok    = in_window && (bus.addressbus[1:0] == 2'b00);
   assign ctrl_hit  = reg_ok && (bus.addressbus[3:2] == 2'd0);
   assign data_hit  = reg_ok && (bus.addressbus[3:2] == 2'd2);

   assign fifo_empty = (count == '0);
   assign fifo_count = count;
   assign full       = (count == FULL_LEVEL);

   // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it.
   assign clear    = bus.writesignal && ctrl_hit && databus[1];
   assign pop      = bus.readsignal && data_hit && !fifo_empty;
   assign push     = in_valid && run_enable && !clear && (!full || pop);
   assign drop_inc = in_valid && run_enable && !clear && full && !pop;

   assign unused_bus = ^databus[31:2];

   always_comb begin
      status         = '0;
      status[AW:0]   = count;
      status[16]     = fifo_empty;
      status[17]     = full;
      status[18]     = (drop != '0);
   end

   always_comb begin
      rd_sel = '0;
      if (reg_ok) begin
         case (bus.addressbus[3:2])
            2'd0:    rd_sel = {31'b0, run_enable};
            2'd1:    rd_sel = status;
            2'd2:    rd_sel = fifo_empty ? 32'h0 : mem[rd_ptr];
            default: rd_sel = drop;
         endcase
      end
   end

   // Release is combinational on the async-reset rd_active so reset frees the bus at once.
   assign databus = (rd_active && in_window && !bus.writesignal) ? rd_hold : 32'bz;

   always_ff @(posedge axi_aclk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         drop       <= '0;
         run_enable <= 1'b0;
         rd_hold    <= '0;
         rd_active  <= 1'b0;
      end else begin
         if (bus.writesignal && ctrl_hit) begin
            run_enable <= databus[0];
         end

         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
               count <= count + CNT_ONE;
            end else if (pop && !push) begin
               count <= count - CNT_ONE;
            end
            if (drop_inc && (drop != 32'hFFFF_FFFF)) begin
               drop <= drop + 32'd1;
            end
         end

         if (bus.readsignal && in_window) begin
            rd_hold   <= rd_sel;
            rd_active <= 1'b1;
         end else if (!in_window || bus.writesignal) begin
            rd_active <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tdc_fifo_regslave.sv
`default_nettype none
// tb_tdc_fifo_regslave: directed vector table plus corner-case sequences, DEPTH=4 instance.
// Revision 1.0
module tb_tdc_fifo_regslave;

   localparam logic [15:0] CTRL   = 16'h0100;
   localparam logic [15:0] STATUS = 16'h0104;
   localparam logic [15:0] DATA   = 16'h0108;
   localparam logic [15:0] DROP   = 16'h010C;
   localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

   localparam int OP_WR   = 0;
   localparam int OP_RD   = 1;
   localparam int OP_PUSH = 2;
   localparam int OP_RDPU = 3;

   typedef struct {
      int          op;
      logic [15:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        run_enable;
   logic        fifo_empty;
   logic [2:0]  fifo_count;
   logic        tb_en;
   logic [31:0] tb_val;
   wire  [31:0] databus;

   int checks;
   int errors;

   tdc_fifo_regslave_if bif ();

   // Pull-up makes a released bus read all ones, distinct from any value the tests expect.
   pullup (databus);
   assign databus = tb_en ? tb_val : 32'bz;

   tdc_fifo_regslave #(
      .base_offset (16'h0100),
      .DEPTH       (4),
      .AW          (2)
   ) dut (
      .axi_aclk    (clk),
      .axi_aresetn (rst_n),
      .bus         (bif),
      .databus     (databus),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .run_enable  (run_enable),
      .fifo_empty  (fifo_empty),
      .fifo_count  (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      bif.writesignal = 1'b1;
      bif.addressbus  = a;
      tb_en  = 1'b1;
      tb_val = d;
      @(negedge clk);
      bif.writesignal = 1'b0;
      bif.addressbus  = 16'h0;
      tb_en = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, input logic with_push,
                           input logic [31:0] pw, output logic [31:0] d);
      @(negedge clk);
      bif.readsignal = 1'b1;
      bif.addressbus = a;
      in_valid = with_push;
      in_data  = pw;
      @(negedge clk);
      bif.readsignal = 1'b0;
      in_valid = 1'b0;
      #1 d = databus;
      @(negedge clk);
      bif.addressbus = 16'h0;
   endtask

   task automatic push_word(input logic [31:0] w);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   vec_t        tbl[$];
   logic [31:0] rd;

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bif.writesignal = 1'b0;
      bif.readsignal  = 1'b0;
      bif.addressbus  = 16'h0;
      in_valid = 1'b0;
      in_data  = 32'h0;
      tb_en    = 1'b0;
      tb_val   = 32'h0;

      tbl.push_back('{OP_RD,   STATUS, 32'h0, 32'h0001_0000, "rst_status"});
      tbl.push_back('{OP_RD,   CTRL,   32'h0, 32'h0000_0000, "rst_ctrl"});
      tbl.push_back('{OP_RD,   DROP,   32'h0, 32'h0000_0000, "rst_drop"});
      tbl.push_back('{OP_WR,   CTRL,   32'h1, 32'h0, "wr_ctrl_en"});
      tbl.push_back('{OP_PUSH, 16'h0,  32'hA5A5_0001, 32'h0, "push1"});
      tbl.push_back('{OP_PUSH, 16'h0,  32'hA5A5_0002, 32'h0, "push2"});
      tbl.push_back('{OP_PUSH, 16'h0,  32'hA5A5_0003, 32'h0, "push3"});
      tbl.push_back('{OP_RD,   STATUS, 32'h0, 32'h0000_0003, "status_3"});
      tbl.push_back('{OP_RD,   DATA,   32'h0, 32'hA5A5_0001, "data1"});
      tbl.push_back('{OP_RD,   DATA,   32'h0, 32'hA5A5_0002, "data2"});
      tbl.push_back('{OP_RD,   DATA,   32'h0, 32'hA5A5_0003, "data3"});
      tbl.push_back('{OP_RD,   DATA,   32'h0, 32'h0000_0000, "data_empty"});
      tbl.push_back('{OP_RD,   STATUS, 32'h0, 32'h0001_0000, "status_empty"});
      for (int i = 1; i <= 6; i++)
         tbl.push_back('{OP_PUSH, 16'h0, 32'hB000_0000 + 32'(i), 32'h0, "push_b"});
      tbl.push_back('{OP_RD,   STATUS, 32'h0, 32'h0006_0004, "status_full"});
      tbl.push_back('{OP_RD,   DROP,   32'h0, 32'h0000_0002, "drop_2"});
      tbl.push_back('{OP_WR,   DROP,   32'h1234_5678, 32'h0, "wr_drop_ro"});
      tbl.push_back('{OP_RD,   DROP,   32'h0, 32'h0000_0002, "drop_ro"});
      tbl.push_back('{OP_RDPU, DATA,   32'hC000_0001, 32'hB000_0001, "pop_push_full"});
      tbl.push_back('{OP_RD,   STATUS, 32'h0, 32'h0006_0004, "status_pp"});
      tbl.push_back('{OP_RD,   DROP,   32'h0, 32'h0000_0002, "drop_pp"});
      tbl.push_back('{OP_WR,   CTRL,   32'h3, 32'h0, "wr_clear"});
      tbl.push_back('{OP_RD,   STATUS, 32'h0, 32'h0001_0000, "status_clr"});
      tbl.push_back('{OP_RD,   DROP,   32'h0, 32'h0000_0000, "drop_clr"});
      tbl.push_back('{OP_RD,   CTRL,   32'h0, 32'h0000_0001, "ctrl_after_clr"});

      repeat (3) @(negedge clk);
      check("rst_count", 32'(fifo_count), 32'h0);
      check("rst_empty", 32'(fifo_empty), 32'h1);
      check("rst_run",   32'(run_enable), 32'h0);
      check("rst_bus",   databus, RELEASED);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         case (tbl[i].op)
            OP_WR:   bus_write(tbl[i].addr, tbl[i].data);
            OP_PUSH: push_word(tbl[i].data);
            OP_RD: begin
               bus_read(tbl[i].addr, 1'b0, 32'h0, rd);
               check(tbl[i].name, rd, tbl[i].exp);
            end
            default: begin
               bus_read(tbl[i].addr, 1'b1, tbl[i].data, rd);
               check(tbl[i].name, rd, tbl[i].exp);
            end
         endcase
      end

      // Disabled: a flood of hits is neither stored nor counted as dropped.
      bus_write(CTRL, 32'h0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'hE000_0001;
      repeat (10) @(negedge clk);
      in_valid = 1'b0;
      check("dis_count", 32'(fifo_count), 32'h0);
      check("dis_empty", 32'(fifo_empty), 32'h1);
      check("dis_run",   32'(run_enable), 32'h0);
      bus_read(DROP, 1'b0, 32'h0, rd);
      check("dis_drop", rd, 32'h0);

      bus_read(16'h0110, 1'b0, 32'h0, rd);
      check("oow_read", rd, RELEASED);

      // Write strobe during a driven read cycle forces release.
      @(negedge clk);
      bif.readsignal = 1'b1;
      bif.addressbus = STATUS;
      @(negedge clk);
      bif.readsignal = 1'b0;
      #1 check("status_drv", databus, 32'h0001_0000);
      bif.writesignal = 1'b1;
      #1 check("wr_nodrive", databus, RELEASED);
      @(negedge clk);
      bif.writesignal = 1'b0;
      #1 check("post_wr_rel", databus, RELEASED);
      bif.addressbus = 16'h0;

      // Reset asserted mid-read while the bus is driven.
      bus_write(CTRL, 32'h1);
      for (int i = 1; i <= 5; i++) push_word(32'hD000_0000 + 32'(i));
      check("pre_rst_count", 32'(fifo_count), 32'h4);
      @(negedge clk);
      bif.readsignal = 1'b1;
      bif.addressbus = DATA;
      @(negedge clk);
      bif.readsignal = 1'b0;
      #1 check("pre_rst_data", databus, 32'hD000_0001);
      #1 rst_n = 1'b0;
      #1 check("rst_mid_bus", databus, RELEASED);
      check("rst_mid_count", 32'(fifo_count), 32'h0);
      check("rst_mid_empty", 32'(fifo_empty), 32'h1);
      check("rst_mid_run",   32'(run_enable), 32'h0);
      @(negedge clk);
      bif.addressbus = 16'h0;
      rst_n = 1'b1;
      bus_read(STATUS, 1'b0, 32'h0, rd);
      check("rst2_status", rd, 32'h0001_0000);
      bus_read(CTRL, 1'b0, 32'h0, rd);
      check("rst2_ctrl", rd, 32'h0);
      bus_read(DROP, 1'b0, 32'h0, rd);
      check("rst2_drop", rd, 32'h0);
      bus_read(DATA, 1'b0, 32'h0, rd);
      check("rst2_data", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tdc_fifo_regslave.md
Name: tdc_fifo_regslave

Overview:
- Local-bus register slave directly downstream of the AXI4-Lite bridge.
- Consumes writesignal/readsignal/addressbus and shares the tri-state databus.
- Buffers 32-bit TDC hit words from the TDC core in a synchronous FIFO, which the host drains by reading a DATA register.
- Exposes CTRL, STATUS and DROP registers for run control and monitoring.

Parameters:
- base_offset, 16'h0100, byte address of CTRL. Must be nonzero and 16-byte aligned.
- DEPTH, 512, FIFO depth in words. Power of 2, range 2..32768.
- AW, 9, log2(DEPTH).

Ports:
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- writesignal  in  1  one-cycle write strobe. databus carries write data in the same cycle.
- readsignal  in  1  one-cycle read strobe. addressbus is valid and stays stable through the following cycle.
- addressbus  in  16  byte address. Reads 0 when no bus access is in progress.
- databus  inout  32  shared data bus. Driven only as defined in Behaviour, otherwise high-Z.
- in_data  in  32  TDC hit word.
- in_valid  in  1  push request, one word per cycle.
- run_enable  out  1  CTRL bit0.
- fifo_empty  out  1  FIFO empty.
- fifo_count  out  AW+1  current fill level.

Behaviour:
- Reset (async, axi_aresetn=0):
  - FIFO pointers = 0, fifo_count = 0, fifo_empty = 1.
  - run_enable = 0, DROP = 0, read hold register = 0.
  - databus = high-Z.
- Register map (hit = addressbus equals base_offset + offset):
  - +0x0 CTRL R/W:
    - bit0 = run_enable.
    - bit1 = clear. Write-1 only, self-clearing, always reads 0.
    - Other bits read 0.
  - +0x4 STATUS RO:
    - [15:0] = fifo_count, zero-extended.
    - [16] = empty, [17] = full, [18] = DROP != 0.
    - [31:19] = 0.
  - +0x8 DATA RO: head word. A read pops the FIFO.
  - +0xC DROP RO: 32-bit saturating count of words lost to a full FIFO.
  - Writes to STATUS, DATA or DROP are ignored. Addresses outside the 16-byte window are ignored entirely.
- Write timing:
  - On the posedge with writesignal=1 and a CTRL hit: run_enable <= databus[0].
  - If databus[1]=1 on that write, a clear is applied in the same edge.
- Clear, applied in one edge:
  - rd/wr pointers = 0, count = 0, DROP = 0.
  - A push in the same cycle is discarded and not counted.
- Read timing:
  - On the posedge with readsignal=1 and any window hit, rd_hold <= the selected register value, and rd_active <= 1.
  - A DATA read when non-empty captures the head word and pops (count-1).
  - A DATA read when empty returns 32'h0 with no pop and no pointer change.
  - rd_active clears on the first posedge where addressbus is outside the window, or when writesignal=1.
  - databus = rd_hold while rd_active=1 AND addressbus is in the window AND writesignal=0. Otherwise high-Z.
  - The result is valid in the cycle after readsignal, the bridge's R_ACK cycle; read latency is 1 cycle.
  - The block never drives databus while writesignal=1.
- Push rules:
  - Push occurs when in_valid=1, run_enable=1, no clear this cycle, and not full.
  - in_valid=1 with run_enable=1 and full: word is dropped and DROP increments, saturating at 32'hFFFF_FFFF.
  - in_valid=1 with run_enable=0: word is ignored and not counted as dropped.
- Simultaneous push and pop:
  - Both happen in the same cycle and count is unchanged.
  - If the FIFO was full, the pop frees a slot, so the push is accepted and not dropped.
  - If the FIFO was empty, the pop is a no-op (returns 0) and the push is accepted. Count goes to 1.
- Pointers: AW bits, wrapping modulo DEPTH. full when count == DEPTH. FIFO memory is inferable as block RAM or distributed RAM; the head word must be available combinationally or prefetched so that the 1-cycle read latency holds.
- Mid-operation reset: state returns to reset values immediately and databus is released asynchronously.

Test Plan:
- Reset, then read STATUS -> databus = 32'h0001_0000 in the R_ACK cycle. Read CTRL -> 0. Read DROP -> 0.
- Write CTRL=1, push 32'hA5A5_0001..32'hA5A5_0003 -> STATUS = 32'h0000_0003. Three DATA reads return the words in order. A fourth DATA read returns 0 and STATUS shows empty.
- DEPTH=4: push 6 words -> STATUS = 32'h0006_0004 (full, drop flag, count 4) and DROP = 2. In one cycle, issue a DATA read together with in_valid -> read returns the first word, count stays 4, DROP stays 2.
- With words buffered, write CTRL=32'h3 (enable plus clear) -> count = 0 and DROP = 0. run_enable stays 1 and CTRL reads back 32'h1.
- CTRL=0 with in_valid held high for 10 cycles -> count 0, DROP 0. Read of base_offset+0x10 -> databus stays high-Z. Whenever writesignal=1, databus is never driven by the block.
- Assert axi_aresetn low mid-read while databus is driven -> databus goes high-Z immediately, and all registers and FIFO state return to their reset values.
